wb_bus_arbiter: RTL and testbench

- Shares the single external Wishbone memory bus between two burst-capable cache masters: master 0 is the instruction cache and master 1 is the data cache, whose refill and writeback sequencer drives cyc/stb/cti/we.
- Grants are registered, round-robin and burst-atomic. Ownership is held until the owner drops cyc, so a dirty-line writeback followed by a refill stays atomic.
- A watchdog terminates a stalled bus cycle with an error pulse.

---
 rtl/wb_bus_arbiter_if.sv | 16 +
 rtl/wb_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_bus_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone B4 bus bundle shared by both cache masters and the external memory slave.
// The master modport drives the request side; the slave modport answers it.
interface wb_bus_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic        ack;
  logic        err;

  modport master (output adr, dat_w, cyc, stb, we, cti, input dat_r, ack, err);
  modport slave  (input adr, dat_w, cyc, stb, we, cti, output dat_r, ack, err);
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: registered round-robin grant, held for a whole cyc,
// one dead cycle between owners, and a stall watchdog that errors out and locks a hung owner.
module wb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_BITS   = 7
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  wb_bus_arbiter_if.slave         m0_if,
  wb_bus_arbiter_if.slave         m1_if,
  wb_bus_arbiter_if.master        s_if,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_e;

  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST =
    TIMEOUT_BITS'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TIMEOUT_BITS-1:0] WDOG_MAX = '1;

  state_e                  state_q, state_d;
  logic                    last_owner_q, last_owner_d;
  logic                    lock0_q, lock0_d;
  logic                    lock1_q, lock1_d;
  logic [TIMEOUT_BITS-1:0] wdog_q, wdog_d;

  logic own0, own1, sel_cyc, sel_stb, stall, timeout, elig0, elig1;
  logic unused_s_err;

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign sel_cyc = own1 ? m1_if.cyc : m0_if.cyc;
  assign sel_stb = own1 ? m1_if.stb : m0_if.stb;
  assign stall   = (own0 | own1) & sel_stb & ~s_if.ack;
  // Ack in the same cycle beats the watchdog because stall already excludes it.
  assign timeout = WDOG_EN && stall && (wdog_q == WDOG_LAST);
  assign elig0   = m0_if.cyc & ~lock0_q;
  assign elig1   = m1_if.cyc & ~lock1_q;

  assign unused_s_err = s_if.err;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      lock0_q      <= 1'b0;
      lock1_q      <= 1'b0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock0_q      <= lock0_d;
      lock1_q      <= lock1_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lock0_d      = lock0_q & m0_if.cyc;
    lock1_d      = lock1_q & m1_if.cyc;
    wdog_d       = '0;
    case (state_q)
      IDLE, TURN: begin
        if (elig0 && (!elig1 || last_owner_q)) state_d = OWN0;
        else if (elig1)                        state_d = OWN1;
        else                                   state_d = IDLE;
      end
      OWN0, OWN1: begin
        if (stall) wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + TIMEOUT_BITS'(1);
        if (timeout || !sel_cyc) begin
          state_d      = TURN;
          last_owner_d = own1;
          wdog_d       = '0;
        end
        // A master that already dropped cyc is not left locked out.
        if (timeout) begin
          if (own0) lock0_d = m0_if.cyc;
          else      lock1_d = m1_if.cyc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_if.adr   = '0;
    s_if.dat_w = '0;
    s_if.cyc   = 1'b0;
    s_if.stb   = 1'b0;
    s_if.we    = 1'b0;
    s_if.cti   = '0;
    m0_if.ack  = 1'b0;
    m1_if.ack  = 1'b0;
    m0_if.err  = 1'b0;
    m1_if.err  = 1'b0;
    grant_o    = 2'b00;
    case (state_q)
      OWN0: begin
        s_if.adr   = m0_if.adr;
        s_if.dat_w = m0_if.dat_w;
        s_if.cyc   = m0_if.cyc;
        s_if.stb   = m0_if.stb;
        s_if.we    = m0_if.we;
        s_if.cti   = m0_if.cti;
        m0_if.ack  = s_if.ack;
        m0_if.err  = timeout;
        grant_o    = 2'b01;
      end
      OWN1: begin
        s_if.adr   = m1_if.adr;
        s_if.dat_w = m1_if.dat_w;
        s_if.cyc   = m1_if.cyc;
        s_if.stb   = m1_if.stb;
        s_if.we    = m1_if.we;
        s_if.cti   = m1_if.cti;
        m1_if.ack  = s_if.ack;
        m1_if.err  = timeout;
        grant_o    = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_if.dat_r = s_if.dat_r;
  assign m1_if.dat_r = s_if.dat_r;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios plus random traffic, all outputs
// compared every cycle against an ownership-level model of the arbitration rules.
module tb_wb_bus_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;

  wb_bus_arbiter_if m0_bus ();
  wb_bus_arbiter_if m1_bus ();
  wb_bus_arbiter_if s_bus ();

  wb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_BITS(3)) dut (
    .clock_i(clk),
    .reset_i(rst),
    .m0_if  (m0_bus),
    .m1_if  (m1_bus),
    .s_if   (s_bus),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus
  logic        rst_drv;
  logic        cyc[2], stb[2], we[2];
  logic [2:0]  cti[2];
  logic [31:0] adr[2], dw[2];
  logic        s_ack;
  logic [31:0] s_dr;

  // observed
  logic [1:0]  g_obs;
  logic        ack_obs[2], err_obs[2];
  logic        s_cyc_obs, s_we_obs;

  // reference model: who owns the bus, tie-break memory, lockouts, stall run length
  int own;
  bit last;
  bit lock[2];
  int stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own = -1; last = 1'b1; lock[0] = 1'b0; lock[1] = 1'b0; stall = 0;
  endtask

  task automatic apply();
    rst          = rst_drv;
    m0_bus.cyc   = cyc[0]; m0_bus.stb = stb[0]; m0_bus.we = we[0];
    m0_bus.cti   = cti[0]; m0_bus.adr = adr[0]; m0_bus.dat_w = dw[0];
    m1_bus.cyc   = cyc[1]; m1_bus.stb = stb[1]; m1_bus.we = we[1];
    m1_bus.cti   = cti[1]; m1_bus.adr = adr[1]; m1_bus.dat_w = dw[1];
    s_bus.ack    = s_ack;  s_bus.dat_r = s_dr;  s_bus.err = 1'b0;
  endtask

  task automatic check_outputs();
    logic [31:0] e_adr, e_dw;
    logic        e_cyc, e_stb, e_we;
    logic [2:0]  e_cti;
    logic        e_ack[2], e_err[2];
    logic [1:0]  e_g;
    e_adr = '0; e_dw = '0; e_cyc = 0; e_stb = 0; e_we = 0; e_cti = '0; e_g = 2'b00;
    e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
    if (!rst_drv && own >= 0) begin
      e_adr = adr[own]; e_dw = dw[own]; e_cyc = cyc[own]; e_stb = stb[own];
      e_we = we[own]; e_cti = cti[own];
      e_ack[own] = s_ack;
      e_err[own] = (stall == TO - 1) && stb[own] && !s_ack;
      e_g = (own == 0) ? 2'b01 : 2'b10;
    end
    check_eq("s_adr",  s_bus.adr,   e_adr);
    check_eq("s_dat",  s_bus.dat_w, e_dw);
    check_eq("s_cyc",  s_bus.cyc,   e_cyc);
    check_eq("s_stb",  s_bus.stb,   e_stb);
    check_eq("s_we",   s_bus.we,    e_we);
    check_eq("s_cti",  s_bus.cti,   e_cti);
    check_eq("m0_ack", m0_bus.ack,  e_ack[0]);
    check_eq("m1_ack", m1_bus.ack,  e_ack[1]);
    check_eq("m0_err", m0_bus.err,  e_err[0]);
    check_eq("m1_err", m1_bus.err,  e_err[1]);
    check_eq("grant",  grant,       e_g);
    check_eq("m0_dat", m0_bus.dat_r, s_dr);
    check_eq("m1_dat", m1_bus.dat_r, s_dr);
    g_obs = grant; ack_obs[0] = m0_bus.ack; ack_obs[1] = m1_bus.ack;
    err_obs[0] = m0_bus.err; err_obs[1] = m1_bus.err;
    s_cyc_obs = s_bus.cyc; s_we_obs = s_bus.we;
  endtask

  task automatic model_step();
    bit n_lock[2];
    bit fire, e0, e1;
    int x;
    if (rst_drv) begin
      model_reset();
      return;
    end
    n_lock[0] = lock[0] && cyc[0];
    n_lock[1] = lock[1] && cyc[1];
    if (own >= 0) begin
      x = own;
      fire = (stall == TO - 1) && stb[x] && !s_ack;
      if (stb[x] && !s_ack) stall++; else stall = 0;
      if (fire) n_lock[x] = cyc[x];
      if (fire || !cyc[x]) begin
        last = (x == 1); own = -1; stall = 0;
      end
    end else begin
      e0 = cyc[0] && !lock[0];
      e1 = cyc[1] && !lock[1];
      if (e0 && e1)  own = last ? 0 : 1;
      else if (e0)   own = 0;
      else if (e1)   own = 1;
      stall = 0;
    end
    lock[0] = n_lock[0];
    lock[1] = n_lock[1];
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      adr[i] = $urandom;
      dw[i]  = $urandom;
    end
    s_dr = $urandom;
    apply();
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; cti[i] = 3'b000;
    end
    s_ack = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_drv = 1;
    cycle();
    cycle();
    rst_drv = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_timeout: finished=0 required=1");
    $fatal(1);
  end

  initial begin
    int beats, a0, k;
    bit saw_we1, saw_we0, started;
    int runs, gap;
    logic [1:0] cur;
    logic [1:0] gseq[$];
    int rem[2];

    idle_all();
    for (int i = 0; i < 2; i++) begin adr[i] = '0; dw[i] = '0; end
    s_dr = '0;
    rst_drv = 1;
    apply();
    model_reset();

    // reset state
    cycle();
    check_eq("rst_grant", g_obs, 2'b00);
    check_eq("rst_s_cyc", s_cyc_obs, 1'b0);
    cycle();
    rst_drv = 0;

    // T1: single m1 8-beat read burst
    cycle();
    cyc[1] = 1; stb[1] = 1; we[1] = 0; cti[1] = 3'b010; s_ack = 1;
    cycle();
    check_eq("t1_grant_wait", g_obs, 2'b00);
    beats = 0; a0 = 0;
    for (int j = 0; j < 20 && beats < 8; j++) begin
      cti[1] = (beats == 7) ? 3'b111 : 3'b010;
      cycle();
      if (j == 0) check_eq("t1_grant", g_obs, 2'b10);
      if (ack_obs[1]) beats++;
      if (ack_obs[0]) a0++;
    end
    check_eq("t1_beats", beats, 8);
    check_eq("t1_m0_ack", a0, 0);
    cyc[1] = 0; stb[1] = 0;
    cycle();
    cycle();
    check_eq("t1_turn", g_obs, 2'b00);
    cycle();
    check_eq("t1_idle", g_obs, 2'b00);

    // T2: simultaneous request after reset, m0 first, one dead cycle
    do_reset();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; s_ack = 1;
    cycle();
    cycle();
    check_eq("t2_first", g_obs, 2'b01);
    cycle();
    cyc[0] = 0; stb[0] = 0;
    cycle();
    check_eq("t2_drop_cyc", s_cyc_obs, 1'b0);
    cycle();
    check_eq("t2_turn", g_obs, 2'b00);
    cycle();
    check_eq("t2_second", g_obs, 2'b10);
    check_eq("t2_s_cyc", s_cyc_obs, 1'b1);
    idle_all();
    for (int j = 0; j < 3; j++) cycle();

    // T3: writeback + refill under one cyc, m0 waiting
    cyc[1] = 1; stb[1] = 1; we[1] = 1; cti[1] = 3'b010; s_ack = 1;
    cycle();
    cyc[0] = 1; stb[0] = 1;
    saw_we1 = 0; saw_we0 = 0;
    for (int j = 0; j < 8; j++) begin
      we[1]  = (j < 4);
      cti[1] = (j == 3 || j == 7) ? 3'b111 : 3'b010;
      cycle();
      check_eq("t3_hold", g_obs, 2'b10);
      if (s_we_obs === 1'b1 && !saw_we0) saw_we1 = 1;
      if (s_we_obs === 1'b0 && saw_we1) saw_we0 = 1;
    end
    check_eq("t3_we_switch", {saw_we1, saw_we0}, 2'b11);
    cyc[1] = 0; stb[1] = 0;
    cycle();
    cycle();
    check_eq("t3_turn", g_obs, 2'b00);
    cycle();
    check_eq("t3_m0_after", g_obs, 2'b01);
    idle_all();
    for (int j = 0; j < 3; j++) cycle();

    // T4: persistent single-beat requests alternate
    do_reset();
    s_ack = 1;
    ack_obs[0] = 0; ack_obs[1] = 0;
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 2; i++) begin
        cyc[i] = !ack_obs[i];
        stb[i] = cyc[i];
      end
      cycle();
      gseq.push_back(g_obs);
    end
    runs = 0; gap = 0; started = 0; cur = 2'b00;
    foreach (gseq[j]) begin
      if (gseq[j] == 2'b00) begin
        if (started) gap++;
      end else if (!started || gap > 0) begin
        if (started) check_eq("t4_gap", gap, 1);
        cur = (runs % 2 == 0) ? 2'b01 : 2'b10;
        check_eq("t4_order", gseq[j], cur);
        runs++; gap = 0; started = 1;
      end else begin
        check_eq("t4_hold", gseq[j], cur);
      end
    end
    check_eq("t4_runs_ge4", runs >= 4, 1);
    idle_all();
    for (int j = 0; j < 3; j++) cycle();

    // T5: watchdog on m0, m1 takes over, m0 locked until it drops cyc
    do_reset();
    cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; s_ack = 0;
    cycle();
    for (int j = 0; j < 4; j++) begin
      cycle();
      check_eq("t5_err", err_obs[0], (j == 3));
    end
    s_ack = 1;
    cycle();
    check_eq("t5_turn", g_obs, 2'b00);
    cycle();
    check_eq("t5_m1", g_obs, 2'b10);
    cyc[1] = 0; stb[1] = 0;
    cycle();
    for (int j = 0; j < 4; j++) begin
      cycle();
      check_eq("t5_locked", g_obs, 2'b00);
    end
    cyc[0] = 0; stb[0] = 0;
    cycle();
    cyc[0] = 1; stb[0] = 1;
    cycle();
    check_eq("t5_wait", g_obs, 2'b00);
    cycle();
    check_eq("t5_regrant", g_obs, 2'b01);
    idle_all();
    for (int j = 0; j < 3; j++) cycle();

    // T6: asynchronous reset mid-burst on m1
    do_reset();
    cyc[1] = 1; stb[1] = 1; cti[1] = 3'b010; s_ack = 1;
    cycle();
    cycle();
    cycle();
    check_eq("t6_owned", g_obs, 2'b10);
    cyc[0] = 1; stb[0] = 1;
    @(posedge clk);
    #2;
    check_eq("t6_pre_ack", m1_bus.ack, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t6_s_cyc", s_bus.cyc, 1'b0);
    check_eq("t6_ack", m1_bus.ack, 1'b0);
    check_eq("t6_grant", grant, 2'b00);
    model_reset();
    rst_drv = 1;
    cycle();
    cycle();
    rst_drv = 0;
    cycle();
    check_eq("t6_idle", g_obs, 2'b00);
    cycle();
    check_eq("t6_m0_first", g_obs, 2'b01);
    idle_all();

    // random traffic
    rem[0] = 0; rem[1] = 0;
    for (k = 0; k < 4000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (rem[i] == 0 && ($urandom % 4 == 0)) begin
          rem[i] = $urandom_range(1, 12);
          we[i]  = $urandom % 2;
        end
        cyc[i] = (rem[i] > 0);
        stb[i] = cyc[i] && ($urandom % 4 != 0);
        case ($urandom % 3)
          0:       cti[i] = 3'b000;
          1:       cti[i] = 3'b010;
          default: cti[i] = 3'b111;
        endcase
        if (rem[i] > 0) rem[i]--;
      end
      if ((k / 200) % 3 == 2) s_ack = ($urandom % 8 == 0);
      else                    s_ack = ($urandom % 3 != 0);
      rst_drv = ($urandom % 500 == 0);
      cycle();
    end
    rst_drv = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
